// File: rtl/cpu_pkg.sv
// Shared types and constants for the front-end redirect logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        DRAIN
    } redirect_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_inflight_tracker.sv
// Tracks outstanding imem requests and how many of them belong to a squashed path,
// dropping their responses as they return in order.
module fetch_inflight_tracker #(
    parameter int  MAX_INFLIGHT = 4,
    localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_fire,
    input  logic          i_rsp_valid,
    input  logic          i_load_stale,
    input  logic          i_count_stale,
    output logic [CW-1:0] o_stale_next,
    output logic          o_rsp_kill,
    output logic          o_hold
);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] stale_q, stale_d;
    logic          rsp_kill;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        inflight_d = inflight_q + CW'(i_req_fire) - CW'(i_rsp_valid);
        rsp_kill   = i_rsp_valid & (stale_q != '0);
        stale_d    = stale_q;
        if (i_load_stale) begin
            // Everything still outstanding after the resolving cycle is wrong-path.
            stale_d = inflight_d;
        end else begin
            stale_d = stale_q + CW'(i_count_stale & i_req_fire) - CW'(rsp_kill);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    assign o_stale_next = stale_d;
    assign o_rsp_kill   = rsp_kill;
    assign o_hold       = (inflight_q == CW'(MAX_INFLIGHT));

endmodule

// File: rtl/branch_redirect_controller.sv
// Detects branch mispredicts at execute and sequences stall, fetch redirect,
// IF/ID flush and squashing of wrong-path imem responses.
module branch_redirect_controller
    import cpu_pkg::*;
#(
    parameter int          MAX_INFLIGHT = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_jump,
    input  logic        i_take_branch,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_pred_taken,
    input  logic [31:0] i_pred_target,
    output logic        o_ex_stall,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ready,
    output logic        o_flush,
    input  logic        i_imem_req_fire,
    input  logic        i_imem_rsp_valid,
    output logic        o_fetch_rsp_kill,
    output logic        o_fetch_hold,
    output logic [31:0] o_mispredict_count
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    redirect_state_t state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;
    logic [31:0]     mispredict_count_q, mispredict_count_d;

    logic            actual_taken;
    logic [31:0]     correct_pc;
    logic            mispredict;
    logic            load_stale;
    logic            count_stale;
    logic [CW-1:0]   stale_next;

    assign o_ex_stall = (state_q == REDIRECT);

    always_comb begin
        actual_taken = i_ex_is_jump | i_take_branch;
        correct_pc   = actual_taken ? i_ex_target : i_ex_pc + INSTR_BYTES;
        mispredict   = i_ex_valid & ~o_ex_stall &
                       ((actual_taken != i_pred_taken) |
                        (actual_taken & (i_ex_target != i_pred_target)));
    end

    always_comb begin
        state_d            = state_q;
        redirect_valid_d   = redirect_valid_q;
        redirect_pc_d      = redirect_pc_q;
        flush_d            = 1'b0;
        mispredict_count_d = mispredict_count_q;
        load_stale         = 1'b0;
        count_stale        = 1'b0;
        case (state_q)
            IDLE, DRAIN: begin
                if (mispredict) begin
                    state_d            = REDIRECT;
                    redirect_valid_d   = 1'b1;
                    redirect_pc_d      = correct_pc;
                    flush_d            = 1'b1;
                    mispredict_count_d = mispredict_count_q + 32'd1;
                    load_stale         = 1'b1;
                end else if (state_q == DRAIN && stale_next == '0) begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                // Fetch is still on the wrong path until the handshake completes.
                count_stale = 1'b1;
                if (i_redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = (stale_next != '0) ? DRAIN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q            <= IDLE;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= RESET_PC;
            flush_q            <= 1'b0;
            mispredict_count_q <= 32'd0;
        end else begin
            state_q            <= state_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            flush_q            <= flush_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    fetch_inflight_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_tracker (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_fire    (i_imem_req_fire),
        .i_rsp_valid   (i_imem_rsp_valid),
        .i_load_stale  (load_stale),
        .i_count_stale (count_stale),
        .o_stale_next  (stale_next),
        .o_rsp_kill    (o_fetch_rsp_kill),
        .o_hold        (o_fetch_hold)
    );

    assign o_redirect_valid   = redirect_valid_q;
    assign o_redirect_pc      = redirect_pc_q;
    assign o_flush            = flush_q;
    assign o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Directed vector bench for branch_redirect_controller: table of per-cycle stimulus
// with hand-computed expectations, followed by a reset-during-redirect sequence.
module tb_branch_redirect_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_jump, take_branch, pred_taken;
    logic [31:0] ex_pc, ex_target, pred_target;
    logic        ex_stall, redirect_valid, redirect_ready, flush;
    logic [31:0] redirect_pc, mispredict_count;
    logic        req_fire, rsp_valid, rsp_kill, fetch_hold;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_redirect_controller #(
        .MAX_INFLIGHT (4),
        .RESET_PC     (32'h0)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ex_valid         (ex_valid),
        .i_ex_is_jump       (ex_is_jump),
        .i_take_branch      (take_branch),
        .i_ex_pc            (ex_pc),
        .i_ex_target        (ex_target),
        .i_pred_taken       (pred_taken),
        .i_pred_target      (pred_target),
        .o_ex_stall         (ex_stall),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_pc      (redirect_pc),
        .i_redirect_ready   (redirect_ready),
        .o_flush            (flush),
        .i_imem_req_fire    (req_fire),
        .i_imem_rsp_valid   (rsp_valid),
        .o_fetch_rsp_kill   (rsp_kill),
        .o_fetch_hold       (fetch_hold),
        .o_mispredict_count (mispredict_count)
    );

    typedef struct {
        logic        ev, jmp, tk;
        logic [31:0] pc, tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        rdy, req, rsp;
        logic        e_kill, e_rv;
        logic [31:0] e_rpc;
        logic        e_flush, e_stall;
        logic [31:0] e_cnt;
        logic        e_hold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ev, jmp, tk, input logic [31:0] pc, tgt,
        input logic pt, input logic [31:0] ptgt,
        input logic rdy, req, rsp,
        input logic e_kill, e_rv, input logic [31:0] e_rpc,
        input logic e_flush, e_stall, input logic [31:0] e_cnt, input logic e_hold);
        vec_t v;
        v.ev = ev; v.jmp = jmp; v.tk = tk; v.pc = pc; v.tgt = tgt;
        v.pt = pt; v.ptgt = ptgt; v.rdy = rdy; v.req = req; v.rsp = rsp;
        v.e_kill = e_kill; v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_flush = e_flush;
        v.e_stall = e_stall; v.e_cnt = e_cnt; v.e_hold = e_hold;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_is_jump = 0; take_branch = 0; pred_taken = 0;
        ex_pc = 0; ex_target = 0; pred_target = 0;
        redirect_ready = 0; req_fire = 0; rsp_valid = 0;
    endtask

    task automatic check_regs(input string tag, input logic rv, input logic [31:0] rpc,
                              input logic fl, input logic st, input logic [31:0] cnt,
                              input logic hold);
        check({tag, " redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check({tag, " redirect_pc"}, redirect_pc, rpc);
        check({tag, " flush"}, 32'(flush), 32'(fl));
        check({tag, " ex_stall"}, 32'(ex_stall), 32'(st));
        check({tag, " mispredict_count"}, mispredict_count, cnt);
        check({tag, " fetch_hold"}, 32'(fetch_hold), 32'(hold));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               ev j  t  pc            tgt           pt ptgt          r  q  s   kill rv rpc           fl st cnt hold
        // correct not-taken prediction
        vecs.push_back(mk(1, 0, 0, 32'h100,      32'h80,       0, 32'h0,       1, 0, 0,  0, 0, 32'h0,        0, 0, 1 - 1, 0));
        // taken branch predicted not-taken, ready high
        vecs.push_back(mk(1, 0, 1, 32'h100,      32'h80,       0, 32'h0,       1, 0, 0,  0, 1, 32'h80,       1, 1, 1, 0));
        // handshake; mispredicting ex input ignored while stalled
        vecs.push_back(mk(1, 0, 1, 32'h300,      32'h400,      0, 32'h0,       1, 0, 0,  0, 0, 32'h80,       0, 0, 1, 0));
        // not-taken predicted taken at top of address space: fall-through wraps
        vecs.push_back(mk(1, 0, 0, 32'hFFFFFFFC, 32'h500,      1, 32'h500,     0, 0, 0,  0, 1, 32'h0,        1, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 0,  0, 1, 32'h0,        0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       1, 0, 0,  0, 0, 32'h0,        0, 0, 2, 0));
        // jump with wrong predicted target
        vecs.push_back(mk(1, 1, 0, 32'h1000,     32'h200,      1, 32'h204,     1, 0, 0,  0, 1, 32'h200,      1, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       1, 0, 0,  0, 0, 32'h200,      0, 0, 3, 0));
        // correct taken prediction
        vecs.push_back(mk(1, 0, 1, 32'h10,       32'h40,       1, 32'h40,      1, 0, 0,  0, 0, 32'h200,      0, 0, 3, 0));
        // two requests in flight, then mispredict with ready low for three cycles
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h200,      0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h200,      0, 0, 3, 0));
        vecs.push_back(mk(1, 0, 1, 32'h2000,     32'h3000,     0, 32'h0,       0, 0, 0,  0, 1, 32'h3000,     1, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 1, 32'h3000,     0, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 0,  0, 1, 32'h3000,     0, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 0,  0, 1, 32'h3000,     0, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       1, 0, 0,  0, 0, 32'h3000,     0, 0, 4, 0));
        // three stale responses killed (one right-path request in DRAIN), fourth passes
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  1, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 1,  1, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  1, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  0, 0, 32'h3000,     0, 0, 4, 0));
        // fill to MAX_INFLIGHT, fetch_hold asserts, then drain
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h3000,     0, 0, 4, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 1,  0, 0, 32'h3000,     0, 0, 4, 0));
        // response in the resolving cycle is not killed; then sit in REDIRECT
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 1, 0,  0, 0, 32'h3000,     0, 0, 4, 0));
        vecs.push_back(mk(1, 0, 1, 32'h40,       32'h4000,     0, 32'h0,       0, 0, 1,  0, 1, 32'h4000,     1, 1, 5, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,       0, 0, 0,  0, 1, 32'h4000,     0, 1, 5, 0));

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", 0, 32'h0, 0, 0, 32'd0, 0);
        check("reset fetch_rsp_kill", 32'(rsp_kill), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ex_valid = vecs[i].ev; ex_is_jump = vecs[i].jmp; take_branch = vecs[i].tk;
            ex_pc = vecs[i].pc; ex_target = vecs[i].tgt;
            pred_taken = vecs[i].pt; pred_target = vecs[i].ptgt;
            redirect_ready = vecs[i].rdy; req_fire = vecs[i].req; rsp_valid = vecs[i].rsp;
            #1;
            check($sformatf("v%0d fetch_rsp_kill", i), 32'(rsp_kill), 32'(vecs[i].e_kill));
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].e_rv, vecs[i].e_rpc, vecs[i].e_flush,
                       vecs[i].e_stall, vecs[i].e_cnt, vecs[i].e_hold);
        end

        // Reset while a redirect is pending abandons it without a flush.
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_regs("rst_in_redirect", 0, 32'h0, 0, 0, 32'd0, 0);
        rst = 1'b0;

        // Inflight must restart at zero: hold only after the fourth request.
        for (int k = 0; k < 4; k++) begin
            req_fire = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("post_rst req%0d fetch_hold", k), 32'(fetch_hold), 32'(k == 3));
            check($sformatf("post_rst req%0d flush", k), 32'(flush), 32'd0);
            check($sformatf("post_rst req%0d redirect_valid", k), 32'(redirect_valid), 32'd0);
        end
        req_fire  = 1'b0;
        rsp_valid = 1'b1;
        #1;
        check("post_rst fetch_rsp_kill", 32'(rsp_kill), 32'd0);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        check("post_rst drain fetch_hold", 32'(fetch_hold), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
